decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 de_npc  input  16  next-PC of the instruction held in the DE latch; not consumed internally.
REQ-004 de_ir  input  16  instruction in the DE latch.
REQ-005 de_v  input  1  DE latch valid.
REQ-006 v_agex_ld_reg, v_mem_ld_reg, v_sr_ld_reg  input  1 each  valid register-write pending in the AGEX, MEM and SR stages.
REQ-007 agex_drid_old, mem_drid, sr_drid  input  3 each  destination register IDs of the AGEX, MEM and SR stages.
REQ-008 sr_reg_data  input  16  write data from the SR stage.
REQ-009 v_agex_ld_cc, v_mem_ld_cc, v_sr_ld_cc  input  1 each  valid CC-write pending in the AGEX, MEM and SR stages.
REQ-010 sr_cc_data  input  3  NZP value from the SR stage.
REQ-011 mem_stall  input  1  memory stage stalled.
REQ-012 v_de_br_stall  output  1  valid control-flow instruction in DE.
REQ-013 dep_stall  output  1  data or CC dependency stall.
REQ-014 ld_agex  output  1  AGEX latch load enable.
REQ-015 agex_sr1, agex_sr2  output  16 each  register-file read data.
REQ-016 agex_drid_new  output  3  destination register ID.
REQ-017 agex_cs  output  20  AGEX-onward control bits.
REQ-018 agex_cc  output  3  current NZP register.
REQ-019 agex_v  output  1  valid bit for the AGEX latch.
REQ-020 reg_contents  output  128  R0 at [15:0] through R7 at [127:112]; observability port.

Function
REQ-021 The register file SHALL be 8x16: rising clk with v_sr_ld_reg=1 writes sr_reg_data to R[sr_drid]; reads are combinational.
REQ-022 The CC register SHALL load sr_cc_data on rising clk when v_sr_ld_cc=1; agex_cc equals the CC register.
REQ-023 The control ROM SHALL have 32 entries, addressed by de_ir[15:11], each entry 25 bits wide.
- [24] BR_STALL
- [23] BR_OP (uses CC)
- [22] SR1_NEEDED
- [21] SR2_NEEDED
- [20] DRMUX
- [19:0] = agex_cs
REQ-024 SR1 SHALL be de_ir[8:6].
REQ-025 SR2 SHALL be de_ir[11:9] if de_ir[13]=1, else de_ir[2:0].
REQ-026 agex_drid_new SHALL be 3'd7 if DRMUX=1, else de_ir[11:9].
REQ-027 The register dependency term SHALL be 1 when either of the following holds for any stage X in {agex, mem, sr}:
- SR1_NEEDED and v_X_ld_reg and X_drid==SR1;
- SR2_NEEDED and v_X_ld_reg and X_drid==SR2.
REQ-028 The CC dependency term SHALL be 1 when BR_OP=1 and any v_*_ld_cc=1.
REQ-029 dep_stall SHALL be de_v AND (register dependency term OR CC dependency term).
REQ-030 v_de_br_stall SHALL be de_v AND BR_STALL.
REQ-031 agex_v SHALL be de_v AND NOT dep_stall.
REQ-032 ld_agex SHALL be NOT mem_stall.
REQ-033 All outputs except reg_contents and agex_cc SHALL be purely combinational (zero latency).
REQ-034 When a write and a read of the same register occur in the same cycle, the read SHALL return the old value; the SR-stage dependency check covers this case.
REQ-035 When v_sr_ld_reg=1 and v_sr_ld_cc=1 in the same cycle, both writes SHALL occur.

Reset
REQ-036 rst_n=0 SHALL asynchronously clear R0-R7 to 16'h0000 and set CC to 3'b010 (Z).

Structure
REQ-037 A shared package SHALL hold:
- the ucode field bit positions;
- the 32-entry control ROM constant;
- the reset CC value.
REQ-038 The register file, including the CC register, SHALL be one sub-module named decode_regfile; the dependency logic and ROM SHALL stay in decode_stage.

Verification
REQ-039 Reset: assert rst_n=0 -> reg_contents==0 and agex_cc==3'b010.
REQ-040 Write and read:
- Stimulus: v_sr_ld_reg=1, sr_drid=3, sr_reg_data=16'h1234 for one edge, then de_ir=16'h12C2 (ADD R1,R3,R2).
- Required: reg_contents[63:48]==16'h1234 and agex_sr1==16'h1234.
REQ-041 Register dependency:
- Stimulus: de_v=1, de_ir=16'h12C2, v_agex_ld_reg=1, agex_drid_old=3.
- Required: dep_stall=1, agex_v=0; with agex_drid_old=4 -> dep_stall=0, agex_v=1.
REQ-042 Branch and CC dependency:
- Stimulus: de_ir=16'h0E05 (BRnzp), de_v=1, v_mem_ld_cc=1.
- Required: dep_stall=1, v_de_br_stall=1; with de_v=0 -> both 0.
REQ-043 Store and JSR decode:
- de_ir=16'h7A40 (STW) -> agex_sr2 equals R5.
- de_ir=16'h4800 (JSR) -> agex_drid_new==7.
REQ-044 Memory stall: mem_stall=1 -> ld_agex=0; mem_stall=0 -> ld_agex=1.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: microcode field positions, the control ROM and the CC reset value.
// The ROM is addressed by {opcode, ir[11]}, so each opcode owns two consecutive entries.
package decode_stage_pkg;

   localparam int unsigned UcodeWidth = 25;
   localparam int unsigned CsWidth    = 20;
   localparam int unsigned NumRegs    = 8;
   localparam int unsigned RegWidth   = 16;

   // Decode-only microcode bits
   localparam int unsigned UcBrStall   = 24;
   localparam int unsigned UcBrOp      = 23;
   localparam int unsigned UcSr1Needed = 22;
   localparam int unsigned UcSr2Needed = 21;
   localparam int unsigned UcDrMux     = 20;

   // agex_cs field positions
   localparam int unsigned CsLdReg     = 19;
   localparam int unsigned CsLdCc      = 18;
   localparam int unsigned CsAlukHi    = 17;
   localparam int unsigned CsAlukLo    = 16;
   localparam int unsigned CsDrValHi   = 15;
   localparam int unsigned CsDrValLo   = 14;
   localparam int unsigned CsAddr1Mux  = 13;
   localparam int unsigned CsAddr2Hi   = 12;
   localparam int unsigned CsAddr2Lo   = 11;
   localparam int unsigned CsLshf1     = 10;
   localparam int unsigned CsAddrMux   = 9;
   localparam int unsigned CsDcacheEn  = 8;
   localparam int unsigned CsDcacheRw  = 7;
   localparam int unsigned CsDataSize  = 6;
   localparam int unsigned CsTrap      = 5;

   localparam logic [2:0] CcReset = 3'b010;

   // Entry layout: BS BO S1 S2 DM | LDREG LDCC ALUK DRVAL A1 A2 LSHF1 AMUX DEN DRW DSZ TRAP | rsvd
   localparam logic [UcodeWidth-1:0] UcNop  = '0;
   localparam logic [UcodeWidth-1:0] UcBr   = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
      1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0};
   localparam logic [UcodeWidth-1:0] UcAdd  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
      1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0};
   localparam logic [UcodeWidth-1:0] UcLdb  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
      1'b1, 1'b1, 2'b00, 2'b10, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b0};
   localparam logic [UcodeWidth-1:0] UcStb  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
      1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b0};
   localparam logic [UcodeWidth-1:0] UcJsrr = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
      1'b1, 1'b0, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0};
   localparam logic [UcodeWidth-1:0] UcJsr  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
      1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0};
   localparam logic [UcodeWidth-1:0] UcAnd  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
      1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0};
   localparam logic [UcodeWidth-1:0] UcLdw  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
      1'b1, 1'b1, 2'b00, 2'b10, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b0};
   localparam logic [UcodeWidth-1:0] UcStw  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
      1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0};
   localparam logic [UcodeWidth-1:0] UcXor  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
      1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0};
   localparam logic [UcodeWidth-1:0] UcJmp  = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
      1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0};
   localparam logic [UcodeWidth-1:0] UcShf  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
      1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0};
   localparam logic [UcodeWidth-1:0] UcLea  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
      1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0};
   localparam logic [UcodeWidth-1:0] UcTrap = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
      1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b0};

   localparam logic [UcodeWidth-1:0] CtrlRom [0:31] = '{
      UcBr,   UcBr,    // 0000 BR
      UcAdd,  UcAdd,   // 0001 ADD
      UcLdb,  UcLdb,   // 0010 LDB
      UcStb,  UcStb,   // 0011 STB
      UcJsrr, UcJsr,   // 0100 JSRR / JSR
      UcAnd,  UcAnd,   // 0101 AND
      UcLdw,  UcLdw,   // 0110 LDW
      UcStw,  UcStw,   // 0111 STW
      UcNop,  UcNop,   // 1000 RTI (unsupported)
      UcXor,  UcXor,   // 1001 XOR
      UcNop,  UcNop,   // 1010 reserved
      UcNop,  UcNop,   // 1011 reserved
      UcJmp,  UcJmp,   // 1100 JMP
      UcShf,  UcShf,   // 1101 SHF
      UcLea,  UcLea,   // 1110 LEA
      UcTrap, UcTrap   // 1111 TRAP
   };

   // True when a needed source register is about to be written by a downstream stage.
   function automatic logic src_hit(input logic needed, input logic ld_v,
                                    input logic [2:0] drid, input logic [2:0] sr);
      return needed & ld_v & (drid == sr);
   endfunction

endpackage

// File: rtl/decode_regfile.sv
// 8x16 register file plus the NZP condition-code register.
// Reads are combinational and see the pre-write value during a same-cycle write.
module decode_regfile
   import decode_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         reg_we,
   input  logic [2:0]   reg_waddr,
   input  logic [15:0]  reg_wdata,
   input  logic         cc_we,
   input  logic [2:0]   cc_wdata,
   input  logic [2:0]   raddr1,
   input  logic [2:0]   raddr2,
   output logic [15:0]  rdata1,
   output logic [15:0]  rdata2,
   output logic [2:0]   cc,
   output logic [127:0] reg_contents
);

   logic [RegWidth-1:0] regs_q [NumRegs];
   logic [2:0]          cc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
         cc_q <= CcReset;
      end else begin
         if (reg_we) begin
            regs_q[reg_waddr] <= reg_wdata;
         end
         if (cc_we) begin
            cc_q <= cc_wdata;
         end
      end
   end

   always_comb begin
      rdata1 = regs_q[raddr1];
      rdata2 = regs_q[raddr2];
      cc     = cc_q;
   end

   always_comb begin
      reg_contents = '0;
      for (int i = 0; i < NumRegs; i++) begin
         reg_contents[i*RegWidth +: RegWidth] = regs_q[i];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: control ROM lookup, register/CC dependency detection and register-file read.
// Everything except the register file state is combinational.
module decode_stage
   import decode_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [15:0]  de_npc,
   input  logic [15:0]  de_ir,
   input  logic         de_v,
   input  logic         v_agex_ld_reg,
   input  logic         v_mem_ld_reg,
   input  logic         v_sr_ld_reg,
   input  logic [2:0]   agex_drid_old,
   input  logic [2:0]   mem_drid,
   input  logic [2:0]   sr_drid,
   input  logic [15:0]  sr_reg_data,
   input  logic         v_agex_ld_cc,
   input  logic         v_mem_ld_cc,
   input  logic         v_sr_ld_cc,
   input  logic [2:0]   sr_cc_data,
   input  logic         mem_stall,
   output logic         v_de_br_stall,
   output logic         dep_stall,
   output logic         ld_agex,
   output logic [15:0]  agex_sr1,
   output logic [15:0]  agex_sr2,
   output logic [2:0]   agex_drid_new,
   output logic [19:0]  agex_cs,
   output logic [2:0]   agex_cc,
   output logic         agex_v,
   output logic [127:0] reg_contents
);

   logic [UcodeWidth-1:0] ucode;
   logic [2:0]            sr1_id;
   logic [2:0]            sr2_id;
   logic                  reg_dep;
   logic                  cc_dep;
   logic                  unused_npc;

   // The next-PC travels alongside the instruction but decode has no use for it.
   assign unused_npc = ^de_npc;

   always_comb begin
      ucode  = CtrlRom[de_ir[15:11]];
      sr1_id = de_ir[8:6];
      sr2_id = de_ir[13] ? de_ir[11:9] : de_ir[2:0];
   end

   always_comb begin
      reg_dep = src_hit(ucode[UcSr1Needed], v_agex_ld_reg, agex_drid_old, sr1_id)
              | src_hit(ucode[UcSr1Needed], v_mem_ld_reg,  mem_drid,      sr1_id)
              | src_hit(ucode[UcSr1Needed], v_sr_ld_reg,   sr_drid,       sr1_id)
              | src_hit(ucode[UcSr2Needed], v_agex_ld_reg, agex_drid_old, sr2_id)
              | src_hit(ucode[UcSr2Needed], v_mem_ld_reg,  mem_drid,      sr2_id)
              | src_hit(ucode[UcSr2Needed], v_sr_ld_reg,   sr_drid,       sr2_id);
      cc_dep  = ucode[UcBrOp] & (v_agex_ld_cc | v_mem_ld_cc | v_sr_ld_cc);
   end

   always_comb begin
      dep_stall     = de_v & (reg_dep | cc_dep);
      v_de_br_stall = de_v & ucode[UcBrStall];
      agex_v        = de_v & ~dep_stall;
      ld_agex       = ~mem_stall;
      agex_drid_new = ucode[UcDrMux] ? 3'd7 : de_ir[11:9];
      agex_cs       = ucode[CsWidth-1:0];
   end

   decode_regfile u_regfile (
      .clk          (clk),
      .rst_n        (rst_n),
      .reg_we       (v_sr_ld_reg),
      .reg_waddr    (sr_drid),
      .reg_wdata    (sr_reg_data),
      .cc_we        (v_sr_ld_cc),
      .cc_wdata     (sr_cc_data),
      .raddr1       (sr1_id),
      .raddr2       (sr2_id),
      .rdata1       (agex_sr1),
      .rdata2       (agex_sr2),
      .cc           (agex_cc),
      .reg_contents (reg_contents)
   );

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: hand sequences for reset and register writes,
// then a vector table driven through a scoreboard queue.
module tb_decode_stage;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [15:0]  de_npc, de_ir;
   logic         de_v;
   logic         v_agex_ld_reg, v_mem_ld_reg, v_sr_ld_reg;
   logic [2:0]   agex_drid_old, mem_drid, sr_drid;
   logic [15:0]  sr_reg_data;
   logic         v_agex_ld_cc, v_mem_ld_cc, v_sr_ld_cc;
   logic [2:0]   sr_cc_data;
   logic         mem_stall;
   logic         v_de_br_stall, dep_stall, ld_agex, agex_v;
   logic [15:0]  agex_sr1, agex_sr2;
   logic [2:0]   agex_drid_new, agex_cc;
   logic [19:0]  agex_cs;
   logic [127:0] reg_contents;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .de_npc        (de_npc),
      .de_ir         (de_ir),
      .de_v          (de_v),
      .v_agex_ld_reg (v_agex_ld_reg),
      .v_mem_ld_reg  (v_mem_ld_reg),
      .v_sr_ld_reg   (v_sr_ld_reg),
      .agex_drid_old (agex_drid_old),
      .mem_drid      (mem_drid),
      .sr_drid       (sr_drid),
      .sr_reg_data   (sr_reg_data),
      .v_agex_ld_cc  (v_agex_ld_cc),
      .v_mem_ld_cc   (v_mem_ld_cc),
      .v_sr_ld_cc    (v_sr_ld_cc),
      .sr_cc_data    (sr_cc_data),
      .mem_stall     (mem_stall),
      .v_de_br_stall (v_de_br_stall),
      .dep_stall     (dep_stall),
      .ld_agex       (ld_agex),
      .agex_sr1      (agex_sr1),
      .agex_sr2      (agex_sr2),
      .agex_drid_new (agex_drid_new),
      .agex_cs       (agex_cs),
      .agex_cc       (agex_cc),
      .agex_v        (agex_v),
      .reg_contents  (reg_contents)
   );

   typedef struct {
      logic [15:0] ir;
      logic        dv;
      logic [2:0]  ldr;     // {agex, mem, sr} register-write valids
      logic [8:0]  drids;   // {agex, mem, sr} destination IDs
      logic [2:0]  ldcc;    // {agex, mem, sr} CC-write valids
      logic        mstall;
      logic        dep, brs, av, lda;
      int          s1, s2;
      logic [2:0]  dr;
      logic        chk_cs;
      logic [19:0] cs;
   } vec_t;

   typedef struct {
      logic        dep, brs, av, lda;
      logic [15:0] sr1, sr2;
      logic [2:0]  dr;
      logic        chk_cs;
      logic [19:0] cs;
   } exp_t;

   vec_t        vecs [$];
   exp_t        sb_q [$];
   logic [15:0] model_regs [8];
   logic [2:0]  model_cc;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] ir, input logic dv, input logic [2:0] ldr,
                               input logic [8:0] drids, input logic [2:0] ldcc,
                               input logic mstall, input logic dep, input logic brs,
                               input logic av, input logic lda, input int s1, input int s2,
                               input logic [2:0] dr, input logic chk_cs,
                               input logic [19:0] cs);
      vec_t v;
      v.ir = ir; v.dv = dv; v.ldr = ldr; v.drids = drids; v.ldcc = ldcc; v.mstall = mstall;
      v.dep = dep; v.brs = brs; v.av = av; v.lda = lda; v.s1 = s1; v.s2 = s2; v.dr = dr;
      v.chk_cs = chk_cs; v.cs = cs;
      return v;
   endfunction

   function automatic logic [127:0] model_contents();
      logic [127:0] r;
      for (int i = 0; i < 8; i++) r[i*16 +: 16] = model_regs[i];
      return r;
   endfunction

   task automatic idle_inputs();
      de_ir = 16'h0; de_v = 1'b0; de_npc = 16'h3000;
      v_agex_ld_reg = 1'b0; v_mem_ld_reg = 1'b0; v_sr_ld_reg = 1'b0;
      agex_drid_old = 3'd0; mem_drid = 3'd0; sr_drid = 3'd0; sr_reg_data = 16'h0;
      v_agex_ld_cc = 1'b0; v_mem_ld_cc = 1'b0; v_sr_ld_cc = 1'b0; sr_cc_data = 3'b0;
      mem_stall = 1'b0;
   endtask

   initial begin
      exp_t e, g;
      vec_t v;

      idle_inputs();
      rst_n = 1'b0;
      #12;
      chk("reset_regs", reg_contents, 128'h0);
      chk("reset_cc", {125'b0, agex_cc}, 128'h2);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) model_regs[i] = 16'h0;

      // Write R3 while ADD R1,R3,R2 reads it: old value until the edge, new value after.
      @(negedge clk);
      de_ir = 16'h12C2; v_sr_ld_reg = 1'b1; sr_drid = 3'd3; sr_reg_data = 16'h1234;
      #1 chk("read_old_same_cycle", {112'b0, agex_sr1}, 128'h0);
      @(posedge clk);
      #1 v_sr_ld_reg = 1'b0;
      chk("write_r3", {112'b0, reg_contents[63:48]}, 128'h1234);
      chk("read_r3_sr1", {112'b0, agex_sr1}, 128'h1234);

      // Preload every register; the last write also loads CC in the same cycle.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         model_regs[i] = 16'h1111 * 16'(i + 1);
         v_sr_ld_reg = 1'b1; sr_drid = 3'(i); sr_reg_data = model_regs[i];
         if (i == 7) begin
            v_sr_ld_cc = 1'b1; sr_cc_data = 3'b100; model_cc = 3'b100;
         end
         @(posedge clk);
         #1 v_sr_ld_reg = 1'b0; v_sr_ld_cc = 1'b0;
      end
      chk("preload_regs", reg_contents, model_contents());
      chk("dual_write_cc", {125'b0, agex_cc}, {125'b0, model_cc});

      //            ir        dv ldr     drids {a,m,s}         ldcc    ms  dep brs av  lda s1 s2 dr    cs? cs
      vecs.push_back(mk(16'h12C2, 1, 3'b100, {3'd3,3'd0,3'd0}, 3'b000, 0, 1, 0, 0, 1, 3, 2, 3'd1, 1, 20'hC0000));
      vecs.push_back(mk(16'h12C2, 1, 3'b100, {3'd4,3'd0,3'd0}, 3'b000, 0, 0, 0, 1, 1, 3, 2, 3'd1, 1, 20'hC0000));
      vecs.push_back(mk(16'h12C2, 1, 3'b010, {3'd0,3'd2,3'd0}, 3'b000, 0, 1, 0, 0, 1, 3, 2, 3'd1, 0, 20'h0));
      vecs.push_back(mk(16'h12C2, 1, 3'b001, {3'd0,3'd0,3'd3}, 3'b000, 0, 1, 0, 0, 1, 3, 2, 3'd1, 0, 20'h0));
      vecs.push_back(mk(16'h12C2, 0, 3'b100, {3'd3,3'd0,3'd0}, 3'b000, 0, 0, 0, 0, 1, 3, 2, 3'd1, 0, 20'h0));
      vecs.push_back(mk(16'h0E05, 1, 3'b000, {3'd0,3'd0,3'd0}, 3'b010, 0, 1, 1, 0, 1, 0, 5, 3'd7, 1, 20'h01400));
      vecs.push_back(mk(16'h0E05, 0, 3'b000, {3'd0,3'd0,3'd0}, 3'b010, 0, 0, 0, 0, 1, 0, 5, 3'd7, 0, 20'h0));
      vecs.push_back(mk(16'h0E05, 1, 3'b100, {3'd0,3'd0,3'd0}, 3'b000, 0, 0, 1, 1, 1, 0, 5, 3'd7, 0, 20'h0));
      vecs.push_back(mk(16'h7A40, 1, 3'b000, {3'd0,3'd0,3'd0}, 3'b000, 0, 0, 0, 1, 1, 1, 5, 3'd5, 1, 20'h02FC0));
      vecs.push_back(mk(16'h7A40, 1, 3'b001, {3'd0,3'd0,3'd5}, 3'b000, 0, 1, 0, 0, 1, 1, 5, 3'd5, 0, 20'h0));
      vecs.push_back(mk(16'h4800, 1, 3'b100, {3'd0,3'd0,3'd0}, 3'b000, 0, 0, 1, 1, 1, 0, 0, 3'd7, 1, 20'h8DC00));
      vecs.push_back(mk(16'h4080, 1, 3'b100, {3'd2,3'd0,3'd0}, 3'b000, 0, 1, 1, 0, 1, 2, 0, 3'd7, 0, 20'h0));
      vecs.push_back(mk(16'h12C2, 1, 3'b000, {3'd0,3'd0,3'd0}, 3'b100, 1, 0, 0, 1, 0, 3, 2, 3'd1, 0, 20'h0));
      vecs.push_back(mk(16'h12C2, 1, 3'b000, {3'd0,3'd0,3'd0}, 3'b000, 0, 0, 0, 1, 1, 3, 2, 3'd1, 0, 20'h0));
      vecs.push_back(mk(16'h0E05, 1, 3'b000, {3'd0,3'd0,3'd0}, 3'b001, 0, 1, 1, 0, 1, 0, 5, 3'd7, 0, 20'h0));

      foreach (vecs[k]) begin
         v = vecs[k];
         @(posedge clk);
         #1;
         de_ir = v.ir; de_v = v.dv; mem_stall = v.mstall;
         {v_agex_ld_reg, v_mem_ld_reg, v_sr_ld_reg} = v.ldr;
         {agex_drid_old, mem_drid, sr_drid} = v.drids;
         {v_agex_ld_cc, v_mem_ld_cc, v_sr_ld_cc} = v.ldcc;
         sr_reg_data = 16'hDEAD; sr_cc_data = 3'b001;
         e.dep = v.dep; e.brs = v.brs; e.av = v.av; e.lda = v.lda;
         e.sr1 = model_regs[v.s1]; e.sr2 = model_regs[v.s2]; e.dr = v.dr;
         e.chk_cs = v.chk_cs; e.cs = v.cs;
         sb_q.push_back(e);
         @(negedge clk);
         g = sb_q.pop_front();
         chk($sformatf("v%0d_dep_stall", k), {127'b0, dep_stall}, {127'b0, g.dep});
         chk($sformatf("v%0d_br_stall", k), {127'b0, v_de_br_stall}, {127'b0, g.brs});
         chk($sformatf("v%0d_agex_v", k), {127'b0, agex_v}, {127'b0, g.av});
         chk($sformatf("v%0d_ld_agex", k), {127'b0, ld_agex}, {127'b0, g.lda});
         chk($sformatf("v%0d_sr1", k), {112'b0, agex_sr1}, {112'b0, g.sr1});
         chk($sformatf("v%0d_sr2", k), {112'b0, agex_sr2}, {112'b0, g.sr2});
         chk($sformatf("v%0d_drid", k), {125'b0, agex_drid_new}, {125'b0, g.dr});
         if (g.chk_cs) chk($sformatf("v%0d_cs", k), {108'b0, agex_cs}, {108'b0, g.cs});
         // Drop write enables before the next edge so the register model stays valid.
         v_sr_ld_reg = 1'b0; v_sr_ld_cc = 1'b0;
      end
      chk("regs_unchanged", reg_contents, model_contents());

      // Asynchronous reset asserted away from any clock edge.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_regs", reg_contents, 128'h0);
      chk("async_reset_cc", {125'b0, agex_cc}, 128'h2);
      @(negedge clk);
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
